// File: rtl/game_sequencer.sv
// Round scheduler for the flappy-bird core: frame tick, phase FSM, player time-sharing, score latches.
// Optional pause support is compiled in with `define PAUSE_EN (adds the pause input and PAUSED state).
module game_sequencer #(
    parameter int unsigned TICK_DIV    = 5000000,
    parameter int unsigned COUNT_TICKS = 30,
    parameter int unsigned OVER_TICKS  = 20,
    parameter int unsigned SCORE_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic               btn_p1,
    input  logic               btn_p2,
    input  logic               core_fail,
    input  logic [SCORE_W-1:0] core_score,
`ifdef PAUSE_EN
    input  logic               pause,
`endif
    output logic               core_rst_n,
    output logic               tick,
    output logic               up_out,
    output logic [2:0]         state,
    output logic               active_player,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [SCORE_W-1:0] best_score,
    output logic [1:0]         winner
);

    localparam int unsigned DIV_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_MAX = (COUNT_TICKS > OVER_TICKS) ? COUNT_TICKS : OVER_TICKS;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_DEAD      = 3'd3,
        S_OVER      = 3'd4,
        S_PAUSED    = 3'd5
    } state_t;

    state_t             st;
    logic [DIV_W-1:0]   div_cnt;
    logic               wrap;
    logic [CNT_W-1:0]   phase_cnt;
    logic               mode_q;
    logic               start_q;
    logic               start_rise;
    logic               up_sel_c;
    logic [SCORE_W-1:0] hi_c;
    logic [SCORE_W-1:0] best_next_c;
    logic [1:0]         winner_next_c;

    assign state      = st;
    assign wrap       = (div_cnt == DIV_W'(TICK_DIV - 1));
    assign start_rise = start & ~start_q;
    assign up_sel_c   = active_player ? btn_p2 : btn_p1;

    // Free-running frame divider; the FSM treats the wrap cycle as the tick event
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (wrap) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

`ifdef PAUSE_EN
    logic pause_q;
    logic pause_rise;

    assign pause_rise = pause & ~pause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause;
        end
    end
`endif

    // End-of-game results, evaluated from the already-latched player scores
    always_comb begin
        hi_c          = (p1_score > p2_score) ? p1_score : p2_score;
        best_next_c   = (hi_c > best_score) ? hi_c : best_score;
        winner_next_c = 2'd1;
        if (mode_q) begin
            if (p1_score > p2_score) begin
                winner_next_c = 2'd1;
            end else if (p2_score > p1_score) begin
                winner_next_c = 2'd2;
            end else begin
                winner_next_c = 2'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= S_IDLE;
            core_rst_n    <= 1'b0;
            tick          <= 1'b0;
            up_out        <= 1'b0;
            active_player <= 1'b0;
            p1_score      <= '0;
            p2_score      <= '0;
            best_score    <= '0;
            winner        <= 2'd0;
            mode_q        <= 1'b0;
            phase_cnt     <= '0;
        end else begin
            tick   <= wrap;
            up_out <= 1'b0;
            case (st)
                S_IDLE: begin
                    core_rst_n <= 1'b0;
                    if (start_rise) begin
                        mode_q        <= mode;
                        active_player <= 1'b0;
                        p1_score      <= '0;
                        p2_score      <= '0;
                        winner        <= 2'd0;
                        phase_cnt     <= '0;
                        st            <= S_COUNTDOWN;
                    end
                end
                S_COUNTDOWN: begin
                    core_rst_n <= 1'b0;
                    if (wrap) begin
                        if (phase_cnt == CNT_W'(COUNT_TICKS - 1)) begin
                            st         <= S_PLAY;
                            core_rst_n <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + CNT_W'(1);
                        end
                    end
                end
                S_PLAY: begin
                    core_rst_n <= 1'b1;
                    if (core_fail) begin
                        st        <= S_DEAD;
                        phase_cnt <= '0;
                        if (active_player) begin
                            p2_score <= core_score;
                        end else begin
                            p1_score <= core_score;
                        end
`ifdef PAUSE_EN
                    end else if (pause_rise) begin
                        st   <= S_PAUSED;
                        tick <= 1'b0;
`endif
                    end else begin
                        up_out <= up_sel_c;
                    end
                end
                S_DEAD: begin
                    core_rst_n <= 1'b1;
                    if (wrap) begin
                        if (phase_cnt == CNT_W'(OVER_TICKS - 1)) begin
                            core_rst_n <= 1'b0;
                            phase_cnt  <= '0;
                            if (mode_q && !active_player) begin
                                active_player <= 1'b1;
                                st            <= S_COUNTDOWN;
                            end else begin
                                st         <= S_OVER;
                                best_score <= best_next_c;
                                winner     <= winner_next_c;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + CNT_W'(1);
                        end
                    end
                end
                S_OVER: begin
                    core_rst_n <= 1'b0;
                    if (start_rise) begin
                        st     <= S_IDLE;
                        winner <= 2'd0;
                    end
                end
`ifdef PAUSE_EN
                S_PAUSED: begin
                    core_rst_n <= 1'b1;
                    tick       <= 1'b0;
                    if (pause_rise) begin
                        st   <= S_PLAY;
                        tick <= wrap;
                    end
                end
`endif
                default: begin
                    st         <= S_IDLE;
                    core_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table plus randomized run against a phase-level model.
module tb_game_sequencer;

    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned COUNT_TICKS = 3;
    localparam int unsigned OVER_TICKS  = 2;
    localparam int unsigned SCORE_W     = 16;

    localparam int P_IDLE = 0, P_CD = 1, P_PLAY = 2, P_DEAD = 3, P_OVER = 4, P_PAUSED = 5;

    logic clk = 1'b0;
    logic rst, start, mode, btn_p1, btn_p2, core_fail, pause;
    logic [SCORE_W-1:0] core_score;
    logic core_rst_n, tick, up_out, active_player;
    logic [2:0] state;
    logic [SCORE_W-1:0] p1_score, p2_score, best_score;
    logic [1:0] winner;

    int vectors = 0;
    int errors  = 0;

    game_sequencer #(
        .TICK_DIV(TICK_DIV), .COUNT_TICKS(COUNT_TICKS),
        .OVER_TICKS(OVER_TICKS), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .btn_p1(btn_p1), .btn_p2(btn_p2), .core_fail(core_fail), .core_score(core_score),
`ifdef PAUSE_EN
        .pause(pause),
`endif
        .core_rst_n(core_rst_n), .tick(tick), .up_out(up_out), .state(state),
        .active_player(active_player), .p1_score(p1_score), .p2_score(p2_score),
        .best_score(best_score), .winner(winner)
    );

    always #5 clk = ~clk;

    // Reference model: game phase, tick count in phase, edges since reset
    int m_edges, m_phase, m_cnt, m_win;
    bit m_act, m_mode, m_up, m_tick, m_sq, m_pq;
    int m_p1, m_p2, m_best;

    task automatic model_step();
        bit wrap, srise, prise;
        if (rst) begin
            m_edges = 0; m_phase = P_IDLE; m_cnt = 0; m_win = 0;
            m_act = 0; m_mode = 0; m_up = 0; m_tick = 0; m_sq = 0; m_pq = 0;
            m_p1 = 0; m_p2 = 0; m_best = 0;
        end else begin
            m_edges++;
            wrap  = (m_edges % TICK_DIV) == 0;
            srise = start && !m_sq;
            prise = pause && !m_pq;
            m_sq  = start;
            m_pq  = pause;
            m_up  = 0;
            case (m_phase)
                P_IDLE: if (srise) begin
                    m_mode = mode; m_act = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
                    m_cnt = 0; m_phase = P_CD;
                end
                P_CD: if (wrap) begin
                    m_cnt++;
                    if (m_cnt == COUNT_TICKS) m_phase = P_PLAY;
                end
                P_PLAY: begin
                    if (core_fail) begin
                        m_phase = P_DEAD; m_cnt = 0;
                        if (m_act) m_p2 = int'(core_score); else m_p1 = int'(core_score);
                    end else if (prise) begin
                        m_phase = P_PAUSED;
                    end else begin
                        m_up = m_act ? btn_p2 : btn_p1;
                    end
                end
                P_DEAD: if (wrap) begin
                    m_cnt++;
                    if (m_cnt == OVER_TICKS) begin
                        if (m_mode && !m_act) begin
                            m_act = 1; m_cnt = 0; m_phase = P_CD;
                        end else begin
                            m_phase = P_OVER;
                            if (m_p1 > m_best) m_best = m_p1;
                            if (m_p2 > m_best) m_best = m_p2;
                            if (!m_mode) m_win = 1;
                            else if (m_p1 > m_p2) m_win = 1;
                            else if (m_p2 > m_p1) m_win = 2;
                            else m_win = 3;
                        end
                    end
                end
                P_OVER: if (srise) begin
                    m_phase = P_IDLE; m_win = 0;
                end
                P_PAUSED: if (prise) m_phase = P_PLAY;
                default: m_phase = P_IDLE;
            endcase
            m_tick = wrap && (m_phase != P_PAUSED);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs the DUT sees, then compare
    task automatic cyc();
        bit crn;
        @(posedge clk);
        model_step();
        #1;
        crn = (m_phase == P_PLAY) || (m_phase == P_DEAD) || (m_phase == P_PAUSED);
        chk("model.state", int'(state), m_phase);
        chk("model.core_rst_n", int'(core_rst_n), int'(crn));
        chk("model.tick", int'(tick), int'(m_tick));
        chk("model.up_out", int'(up_out), int'(m_up));
        chk("model.active_player", int'(active_player), int'(m_act));
        chk("model.p1_score", int'(p1_score), m_p1);
        chk("model.p2_score", int'(p2_score), m_p2);
        chk("model.best_score", int'(best_score), m_best);
        chk("model.winner", int'(winner), m_win);
    endtask

    typedef struct {
        int rst, start, mode, b1, b2, fail, score, ncyc;
        int st, crn, act, up, tk, p1, p2, best, win;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int r, int s, int md, int b1, int b2, int f, int sc, int n,
                                int st, int crn, int act, int up, int tk,
                                int p1, int p2, int best, int win);
        vec_t v;
        v = '{r, s, md, b1, b2, f, sc, n, st, crn, act, up, tk, p1, p2, best, win};
        return v;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; btn_p1 = 1'b0; btn_p2 = 1'b0;
        core_fail = 1'b0; core_score = '0; pause = 1'b0;

        // rst st md b1 b2 f sc  n | st crn act up tk p1 p2 best win
        tbl.push_back(mk(1,0,0,0,0,0,0, 2,  0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 3,  0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,  0,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 1,  1,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,10,  1,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,  2,1,0,0,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0, 1,  2,1,0,1,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0, 1,  2,1,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,1,7, 1,  3,1,0,0,0, 7,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 4,  3,1,0,0,0, 7,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,  4,0,0,0,1, 7,0,7,1));
        tbl.push_back(mk(0,1,0,0,0,0,0, 1,  0,0,0,0,0, 7,0,7,0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 3,  0,0,0,0,1, 7,0,7,0));
        tbl.push_back(mk(0,0,1,0,0,0,0, 1,  0,0,0,0,0, 7,0,7,0));
        tbl.push_back(mk(0,1,1,0,0,0,0, 1,  1,0,0,0,0, 0,0,7,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,10,  2,1,0,0,1, 0,0,7,0));
        tbl.push_back(mk(0,0,1,0,1,0,0, 1,  2,1,0,0,0, 0,0,7,0));
        tbl.push_back(mk(0,0,0,1,0,0,0, 1,  2,1,0,1,0, 0,0,7,0));
        tbl.push_back(mk(0,0,0,0,0,1,5, 1,  3,1,0,0,0, 5,0,7,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 5,  1,0,1,0,1, 5,0,7,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,12,  2,1,1,0,1, 5,0,7,0));
        tbl.push_back(mk(0,0,0,1,0,0,0, 1,  2,1,1,0,0, 5,0,7,0));
        tbl.push_back(mk(0,0,0,0,1,0,0, 1,  2,1,1,1,0, 5,0,7,0));
        tbl.push_back(mk(0,0,0,0,0,1,9, 1,  3,1,1,0,0, 5,9,7,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 5,  4,0,1,0,1, 5,9,9,2));
        tbl.push_back(mk(0,1,0,0,0,0,0, 1,  0,0,1,0,0, 5,9,9,0));
        tbl.push_back(mk(0,0,1,0,0,0,0, 1,  0,0,1,0,0, 5,9,9,0));
        tbl.push_back(mk(0,1,1,0,0,0,0, 1,  1,0,0,0,0, 0,0,9,0));
        tbl.push_back(mk(0,0,1,0,0,0,0, 9,  2,1,0,0,1, 0,0,9,0));
        tbl.push_back(mk(0,0,1,0,0,1,4, 1,  3,1,0,0,0, 4,0,9,0));
        tbl.push_back(mk(0,0,1,0,0,0,0, 7,  1,0,1,0,1, 4,0,9,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,12,  2,1,1,0,1, 4,0,9,0));
        tbl.push_back(mk(0,0,1,0,0,1,4, 1,  3,1,1,0,0, 4,4,9,0));
        tbl.push_back(mk(0,1,1,0,0,0,0, 7,  4,0,1,0,1, 4,4,9,3));
        tbl.push_back(mk(0,1,1,0,0,0,0, 3,  4,0,1,0,0, 4,4,9,3));
        tbl.push_back(mk(0,0,1,0,0,0,0, 1,  4,0,1,0,1, 4,4,9,3));
        tbl.push_back(mk(0,1,0,0,0,0,0, 1,  0,0,1,0,0, 4,4,9,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,  0,0,1,0,0, 4,4,9,0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 1,  1,0,0,0,0, 0,0,9,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 9,  2,1,0,0,1, 0,0,9,0));
        tbl.push_back(mk(0,0,0,0,0,1,3, 1,  3,1,0,0,0, 3,0,9,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 1,  0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 3,  0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,  0,0,0,0,1, 0,0,0,0));

        foreach (tbl[i]) begin
            rst        = (tbl[i].rst != 0);
            start      = (tbl[i].start != 0);
            mode       = (tbl[i].mode != 0);
            btn_p1     = (tbl[i].b1 != 0);
            btn_p2     = (tbl[i].b2 != 0);
            core_fail  = (tbl[i].fail != 0);
            core_score = SCORE_W'(tbl[i].score);
            for (int k = 0; k < tbl[i].ncyc; k++) cyc();
            chk($sformatf("row%0d.state", i), int'(state), tbl[i].st);
            chk($sformatf("row%0d.core_rst_n", i), int'(core_rst_n), tbl[i].crn);
            chk($sformatf("row%0d.active_player", i), int'(active_player), tbl[i].act);
            chk($sformatf("row%0d.up_out", i), int'(up_out), tbl[i].up);
            chk($sformatf("row%0d.tick", i), int'(tick), tbl[i].tk);
            chk($sformatf("row%0d.p1_score", i), int'(p1_score), tbl[i].p1);
            chk($sformatf("row%0d.p2_score", i), int'(p2_score), tbl[i].p2);
            chk($sformatf("row%0d.best_score", i), int'(best_score), tbl[i].best);
            chk($sformatf("row%0d.winner", i), int'(winner), tbl[i].win);
        end

        // Randomized play against the model
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) start = ~start;
            mode       = 1'($urandom);
            btn_p1     = 1'($urandom);
            btn_p2     = 1'($urandom);
            core_fail  = ($urandom_range(0, 15) == 0);
            core_score = SCORE_W'($urandom_range(0, 40));
`ifdef PAUSE_EN
            if ($urandom_range(0, 9) == 0) pause = ~pause;
`endif
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
